// File: rtl/pcs_tx_ordered_set_pkg.sv
// pcs_tx_ordered_set_pkg
//   Shared definitions for the 1000BASE-X PCS transmit ordered-set generator:
//   8b code-group values (named as in the encoder code tables), the FSM
//   state type and a helper that picks the second /I/ code-group.
package pcs_tx_ordered_set_pkg;

   // Control (K) code-groups
   localparam logic [7:0] SPECIAL_CODE_K23_7_8B = 8'hF7;   // /R/
   localparam logic [7:0] SPECIAL_CODE_K27_7_8B = 8'hFB;   // /S/
   localparam logic [7:0] SPECIAL_CODE_K28_5_8B = 8'hBC;   // comma, first half of /I/
   localparam logic [7:0] SPECIAL_CODE_K29_7_8B = 8'hFD;   // /T/
   localparam logic [7:0] SPECIAL_CODE_K30_7_8B = 8'hFE;   // /V/

   // Data code-groups used as the second half of /I/
   localparam logic [7:0] SPECIAL_CODE_D5_6_8B  = 8'hC5;   // I1: keeps RD- after RD-
   localparam logic [7:0] SPECIAL_CODE_D16_2_8B = 8'h50;   // I2: flips RD+ back to RD-

   // States are named after the code-group emitted last
   typedef enum logic [2:0] {
      IDLE_K = 3'd0,
      IDLE_D = 3'd1,
      SOP    = 3'd2,
      DATA   = 3'd3,
      EOP_T  = 3'd4,
      EOP_R  = 3'd5
   } tx_state_t;

   // Second /I/ code-group: I2 when the running disparity is positive so the
   // line always returns to RD- after an idle, I1 otherwise.
   function automatic logic [7:0] idle_d_code(input logic disparity_pos);
      return disparity_pos ? SPECIAL_CODE_D16_2_8B : SPECIAL_CODE_D5_6_8B;
   endfunction

endpackage

// File: rtl/pcs_tx_ordered_set.sv
// pcs_tx_ordered_set
//   1000BASE-X PCS transmit code-group generator. Converts GMII transmit
//   signals into one 8-bit code-group per clock for the 8B/10B encoder,
//   inserting /I/, /S/, /T/, /R/ and /V/ ordered sets.
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   TX_EN, TX_ER, TXD     GMII transmit interface
//   tx_disparity_pos      encoder running disparity for the next group (1 = RD+)
//   tx_code_group_8b      code-group to encoder
//   tx_is_k               1 = control code-group
//   tx_even               1 = current code-group occupies an even slot
//   transmitting          1 while /S/, data, /V/ or /T/ is output
//   frame_count           number of /T/ code-groups emitted (wraps)
module pcs_tx_ordered_set
   import pcs_tx_ordered_set_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             TX_EN,
   input  logic             TX_ER,
   input  logic [7:0]       TXD,
   input  logic             tx_disparity_pos,
   output logic [7:0]       tx_code_group_8b,
   output logic             tx_is_k,
   output logic             tx_even,
   output logic             transmitting,
   output logic [CNT_W-1:0] frame_count
);

   tx_state_t        state_r;
   logic [7:0]       code_r;
   logic             is_k_r;
   logic             even_r;
   logic             transmitting_r;
   logic [CNT_W-1:0] frame_count_r;

   // Slot parity of the group produced at this edge (even_r toggles every cycle)
   logic next_even_s;
   assign next_even_s = ~even_r;

   // Ordered-set FSM, slot parity and frame counter; every output is registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE_K;
         code_r         <= SPECIAL_CODE_K28_5_8B;
         is_k_r         <= 1'b1;
         even_r         <= 1'b1;
         transmitting_r <= 1'b0;
         frame_count_r  <= {CNT_W{1'b0}};
      end else begin
         even_r <= next_even_s;
         case (state_r)
            IDLE_K: begin
               // TX_EN is ignored here: the idle pair is always completed
               state_r        <= IDLE_D;
               code_r         <= idle_d_code(tx_disparity_pos);
               is_k_r         <= 1'b0;
               transmitting_r <= 1'b0;
            end
            IDLE_D: begin
               if (TX_EN) begin
                  // TXD at this edge is a preamble byte replaced by /S/
                  state_r        <= SOP;
                  code_r         <= SPECIAL_CODE_K27_7_8B;
                  is_k_r         <= 1'b1;
                  transmitting_r <= 1'b1;
               end else begin
                  state_r        <= IDLE_K;
                  code_r         <= SPECIAL_CODE_K28_5_8B;
                  is_k_r         <= 1'b1;
                  transmitting_r <= 1'b0;
               end
            end
            SOP, DATA: begin
               if (TX_EN && !TX_ER) begin
                  state_r        <= DATA;
                  code_r         <= TXD;
                  is_k_r         <= 1'b0;
                  transmitting_r <= 1'b1;
               end else if (TX_EN) begin
                  state_r        <= DATA;
                  code_r         <= SPECIAL_CODE_K30_7_8B;
                  is_k_r         <= 1'b1;
                  transmitting_r <= 1'b1;
               end else begin
                  state_r        <= EOP_T;
                  code_r         <= SPECIAL_CODE_K29_7_8B;
                  is_k_r         <= 1'b1;
                  transmitting_r <= 1'b1;
                  frame_count_r  <= frame_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            EOP_T: begin
               state_r        <= EOP_R;
               code_r         <= SPECIAL_CODE_K23_7_8B;
               is_k_r         <= 1'b1;
               transmitting_r <= 1'b0;
            end
            EOP_R: begin
               // Pad with /R/ until the next /I/ starts on an even slot
               if (next_even_s) begin
                  state_r <= IDLE_K;
                  code_r  <= SPECIAL_CODE_K28_5_8B;
               end else begin
                  state_r <= EOP_R;
                  code_r  <= SPECIAL_CODE_K23_7_8B;
               end
               is_k_r         <= 1'b1;
               transmitting_r <= 1'b0;
            end
            default: begin
               // Unreachable encodings recover to idle
               state_r        <= IDLE_K;
               code_r         <= SPECIAL_CODE_K28_5_8B;
               is_k_r         <= 1'b1;
               transmitting_r <= 1'b0;
            end
         endcase
      end
   end

   assign tx_code_group_8b = code_r;
   assign tx_is_k          = is_k_r;
   assign tx_even          = even_r;
   assign transmitting     = transmitting_r;
   assign frame_count      = frame_count_r;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// tb_pcs_tx_ordered_set
//   Self-checking bench for pcs_tx_ordered_set: a table of directed vectors,
//   a randomized phase compared against a stream-level reference model, and a
//   hand-written misaligned-start sequence.
module tb_pcs_tx_ordered_set;

   logic        clk;
   logic        reset;
   logic        TX_EN;
   logic        TX_ER;
   logic [7:0]  TXD;
   logic        tx_disparity_pos;
   logic [7:0]  tx_code_group_8b;
   logic        tx_is_k;
   logic        tx_even;
   logic        transmitting;
   logic [15:0] frame_count;

   int checks;
   int errors;

   pcs_tx_ordered_set #(.CNT_W(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .TX_EN            (TX_EN),
      .TX_ER            (TX_ER),
      .TXD              (TXD),
      .tx_disparity_pos (tx_disparity_pos),
      .tx_code_group_8b (tx_code_group_8b),
      .tx_is_k          (tx_is_k),
      .tx_even          (tx_even),
      .transmitting     (transmitting),
      .frame_count      (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       en;
      logic       er;
      logic [7:0] d;
      logic       dp;
      logic [7:0] code;
      logic       k;
      logic       even;
      logic       tx;
      int         cnt;
   } vec_t;

   vec_t vecs[$];

   // Reference model: works on the emitted stream (last group + slot parity)
   logic [7:0] m_code;
   logic       m_k;
   logic       m_even;
   logic       m_tx;
   int         m_cnt;
   logic       m_in_frame;

   task automatic model_edge(input logic r, input logic en, input logic er,
                             input logic [7:0] d, input logic dp);
      logic slot_even;
      if (r) begin
         m_code = 8'hBC; m_k = 1'b1; m_even = 1'b1; m_tx = 1'b0;
         m_cnt = 0; m_in_frame = 1'b0;
      end else begin
         slot_even = ~m_even;
         if (m_in_frame) begin
            if (en && !er)  begin m_code = d;     m_k = 1'b0; m_tx = 1'b1; end
            else if (en)    begin m_code = 8'hFE; m_k = 1'b1; m_tx = 1'b1; end
            else begin
               m_code = 8'hFD; m_k = 1'b1; m_tx = 1'b1;
               m_in_frame = 1'b0;
               m_cnt = (m_cnt + 1) % 65536;
            end
         end else if (m_k && m_code == 8'hBC) begin
            m_code = dp ? 8'h50 : 8'hC5; m_k = 1'b0; m_tx = 1'b0;
         end else if (!m_k) begin
            if (en) begin m_code = 8'hFB; m_k = 1'b1; m_tx = 1'b1; m_in_frame = 1'b1; end
            else    begin m_code = 8'hBC; m_k = 1'b1; m_tx = 1'b0; end
         end else if (m_code == 8'hFD) begin
            m_code = 8'hF7; m_k = 1'b1; m_tx = 1'b0;
         end else begin
            m_code = slot_even ? 8'hBC : 8'hF7; m_k = 1'b1; m_tx = 1'b0;
         end
         m_even = slot_even;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Apply inputs for one edge, advance the model, settle past the edge
   task automatic step(input logic r, input logic en, input logic er,
                       input logic [7:0] d, input logic dp);
      reset = r; TX_EN = en; TX_ER = er; TXD = d; tx_disparity_pos = dp;
      @(posedge clk);
      model_edge(r, en, er, d, dp);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [7:0] code, input logic k,
                            input logic even, input logic tx, input int cnt);
      check({tag, " code"}, int'(tx_code_group_8b), int'(code));
      check({tag, " is_k"}, int'(tx_is_k), int'(k));
      check({tag, " even"}, int'(tx_even), int'(even));
      check({tag, " transmitting"}, int'(transmitting), int'(tx));
      check({tag, " frame_count"}, int'(frame_count), cnt);
   endtask

   task automatic add(input logic r, input logic en, input logic er, input logic [7:0] d,
                      input logic dp, input logic [7:0] code, input logic k,
                      input logic even, input logic tx, input int cnt);
      vec_t v;
      v.r = r; v.en = en; v.er = er; v.d = d; v.dp = dp;
      v.code = code; v.k = k; v.even = even; v.tx = tx; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   initial begin
      logic en_r;
      checks = 0; errors = 0;
      reset = 1'b1; TX_EN = 1'b0; TX_ER = 1'b0; TXD = 8'h00; tx_disparity_pos = 1'b0;
      m_code = 8'hBC; m_k = 1'b1; m_even = 1'b1; m_tx = 1'b0; m_cnt = 0; m_in_frame = 1'b0;

      //   r  en er  txd    dp  code   k  ev tx cnt
      add(1, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0);   // reset state
      add(0, 0, 0, 8'h00, 1, 8'h50, 0, 0, 0, 0);   // idle, RD+ -> I2
      add(0, 0, 0, 8'h00, 1, 8'hBC, 1, 1, 0, 0);
      add(0, 0, 0, 8'h00, 1, 8'h50, 0, 0, 0, 0);
      add(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0);
      add(0, 0, 0, 8'h00, 0, 8'hC5, 0, 0, 0, 0);   // idle, RD- -> I1
      add(0, 0, 1, 8'h11, 0, 8'hBC, 1, 1, 0, 0);   // carrier extension = idle
      add(0, 0, 1, 8'h22, 0, 8'hC5, 0, 0, 0, 0);
      add(0, 1, 0, 8'h55, 0, 8'hFB, 1, 1, 1, 0);   // aligned start, 55 dropped
      add(0, 1, 0, 8'hA1, 0, 8'hA1, 0, 0, 1, 0);
      add(0, 1, 0, 8'hA2, 0, 8'hA2, 0, 1, 1, 0);
      add(0, 1, 0, 8'hA3, 0, 8'hA3, 0, 0, 1, 0);
      add(0, 0, 0, 8'h00, 0, 8'hFD, 1, 1, 1, 1);   // /T/
      add(0, 0, 0, 8'h00, 0, 8'hF7, 1, 0, 0, 1);   // /R/ on odd slot
      add(0, 1, 0, 8'h77, 0, 8'hBC, 1, 1, 0, 1);   // TX_EN in EOP_R ignored
      add(0, 1, 0, 8'h55, 1, 8'h50, 0, 0, 0, 1);   // TX_EN in IDLE_K ignored
      add(0, 1, 0, 8'h55, 1, 8'hFB, 1, 1, 1, 1);
      add(0, 1, 0, 8'h10, 0, 8'h10, 0, 0, 1, 1);
      add(0, 1, 1, 8'h20, 0, 8'hFE, 1, 1, 1, 1);   // error -> /V/
      add(0, 1, 0, 8'h30, 0, 8'h30, 0, 0, 1, 1);
      add(0, 1, 0, 8'hC5, 0, 8'hC5, 0, 1, 1, 1);
      add(0, 0, 0, 8'h00, 0, 8'hFD, 1, 0, 1, 2);
      add(0, 0, 0, 8'h00, 0, 8'hF7, 1, 1, 0, 2);
      add(0, 0, 0, 8'h00, 0, 8'hF7, 1, 0, 0, 2);   // extra /R/
      add(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 2);
      add(0, 0, 0, 8'h00, 0, 8'hC5, 0, 0, 0, 2);
      add(0, 1, 0, 8'h55, 0, 8'hFB, 1, 1, 1, 2);
      add(0, 1, 0, 8'hAA, 0, 8'hAA, 0, 0, 1, 2);
      add(1, 1, 0, 8'hBB, 0, 8'hBC, 1, 1, 0, 0);   // reset mid-frame
      add(0, 1, 0, 8'hCC, 1, 8'h50, 0, 0, 0, 0);   // no /T/ after reset
      add(0, 1, 0, 8'h55, 1, 8'hFB, 1, 1, 1, 0);
      add(0, 0, 0, 8'h00, 0, 8'hFD, 1, 0, 1, 1);   // empty frame
      add(0, 0, 0, 8'h00, 0, 8'hF7, 1, 1, 0, 1);
      add(0, 0, 0, 8'h00, 0, 8'hF7, 1, 0, 0, 1);
      add(0, 0, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 1);

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].en, vecs[i].er, vecs[i].d, vecs[i].dp);
         check_all($sformatf("vec%0d", i), vecs[i].code, vecs[i].k, vecs[i].even,
                   vecs[i].tx, vecs[i].cnt);
      end

      // Randomized traffic against the reference model
      en_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic r;
         r = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 9) < 2) en_r = ~en_r;
         step(r, en_r, ($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom));
         check_all($sformatf("rnd%0d", i), m_code, m_k, m_even, m_tx, m_cnt);
      end

      // Misaligned start: TX_EN rises while the comma is being sent
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check("mis reset code", int'(tx_code_group_8b), 32'hBC);
      step(1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
      check("mis idle_d code", int'(tx_code_group_8b), 32'hC5);
      check("mis idle_d transmitting", int'(transmitting), 0);
      step(1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
      check("mis sop code", int'(tx_code_group_8b), 32'hFB);
      check("mis sop even", int'(tx_even), 1);
      step(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0);
      check("mis first data", int'(tx_code_group_8b), 32'hA1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check("mis eop code", int'(tx_code_group_8b), 32'hFD);
      check("mis frame_count", int'(frame_count), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
